// File: rtl/consec_pkg.sv
// Shared types and record-layout helpers for the consecutive-run logger slice.
// A record is {start_ts, run_len}; run_len occupies the low LEN_W bits.
package consec_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned TS_W_DEF  = 16;
    localparam int unsigned LEN_W_DEF = 8;
    localparam int unsigned LEN_LSB   = 0;

    function automatic int unsigned rec_w(input int unsigned ts_w, input int unsigned len_w);
        return ts_w + len_w;
    endfunction

endpackage

// File: rtl/consec_evt_fifo.sv
// First-word fall-through record FIFO with synchronous flush.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module consec_evt_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push;
    logic         do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full FIFO is still taken when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[AW-1:0]] = wdata;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/consec_run_logger.sv
// Measures each contiguous run of consec4=1, timestamps its start and queues
// qualifying {start_ts, run_len} records for a valid/ready consumer.
module consec_run_logger
    import consec_pkg::*;
#(
    parameter int unsigned TS_W    = TS_W_DEF,
    parameter int unsigned LEN_W   = LEN_W_DEF,
    parameter int unsigned MIN_LEN = 1,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             consec4,
    input  logic             clr,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [TS_W-1:0]  evt_ts,
    output logic [LEN_W-1:0] evt_len,
    output logic [CNT_W-1:0] evt_count,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned      REC_W   = rec_w(TS_W, LEN_W);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);

    state_e           state_q, state_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [TS_W-1:0]  start_q, start_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [REC_W-1:0] wdata;
    logic [REC_W-1:0] rdata;

    always_comb begin
        ts_d    = ts_q + 1'b1;
        state_d = state_q;
        start_d = start_q;
        len_d   = len_q;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (consec4) begin
                    state_d = ST_RUN;
                    start_d = ts_q;
                    len_d   = LEN_W'(1);
                end
            end
            ST_RUN: begin
                if (consec4) begin
                    if (len_q != '1) begin
                        len_d = len_q + 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                    len_d   = '0;
                    push    = (len_q >= LEN_MIN);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (clr) begin
            state_d = ST_IDLE;
            len_d   = '0;
            push    = 1'b0;
        end
    end

    assign pop = evt_valid && evt_ready;

    // Every qualifying end is counted even when the FIFO has to drop it.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (push) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (fifo_full && !pop) begin
                ovf_d = 1'b1;
            end
        end
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ts_q    <= '0;
            state_q <= ST_IDLE;
            start_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ts_q    <= ts_d;
            state_q <= state_d;
            start_q <= start_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wdata = {start_q, len_q};

    consec_evt_fifo #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST),
        .flush (clr),
        .push  (push),
        .pop   (evt_ready),
        .wdata (wdata),
        .rdata (rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign evt_valid = !fifo_empty;
    assign evt_ts    = rdata[REC_W-1:LEN_W];
    assign evt_len   = rdata[LEN_W-1:LEN_LSB];
    assign evt_count = cnt_q;
    assign overflow  = ovf_q;
    assign busy      = (state_q == ST_RUN);

endmodule

// File: tb/tb_consec_run_logger.sv
// Scoreboard bench for consec_run_logger: stimulus queues expected records,
// a negedge monitor pops and compares on every accepted handshake.
module tb_consec_run_logger;

    localparam int unsigned TS_W    = 4;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned MIN_LEN = 2;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CNT_W   = 16;

    logic             CLK       = 1'b0;
    logic             RST       = 1'b0;
    logic             consec4   = 1'b0;
    logic             clr       = 1'b0;
    logic             evt_ready = 1'b0;
    logic             evt_valid;
    logic [TS_W-1:0]  evt_ts;
    logic [LEN_W-1:0] evt_len;
    logic [CNT_W-1:0] evt_count;
    logic             overflow;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [TS_W+LEN_W-1:0] sb [$];
    logic [TS_W+LEN_W-1:0] exp_rec;
    logic [TS_W-1:0]       tb_ts;

    consec_run_logger #(
        .TS_W    (TS_W),
        .LEN_W   (LEN_W),
        .MIN_LEN (MIN_LEN),
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .consec4   (consec4),
        .clr       (clr),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ts    (evt_ts),
        .evt_len   (evt_len),
        .evt_count (evt_count),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    // Edge count since reset release, used to pick and record run start times.
    always @(posedge CLK or negedge RST) begin
        if (!RST) tb_ts <= '0;
        else      tb_ts <= tb_ts + 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RST && evt_valid && evt_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_record: got ts=%0d len=%0d expected none", evt_ts, evt_len);
            end else begin
                exp_rec = sb.pop_front();
                check("rec_ts", 32'(evt_ts), 32'(exp_rec[TS_W+LEN_W-1:LEN_W]));
                check("rec_len", 32'(evt_len), 32'(exp_rec[LEN_W-1:0]));
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic wait_ts(input int v);
        int n;
        n = 0;
        while (tb_ts != TS_W'(v) && n < 64) begin
            step();
            n++;
        end
        if (tb_ts != TS_W'(v)) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_ts: got %0d expected %0d", tb_ts, v);
        end
    endtask

    task automatic run(input int len, input int gap, input bit store, input int exp_ts,
                       input int exp_len, input bit pop_at_end);
        logic [TS_W-1:0] st;
        st = (exp_ts < 0) ? tb_ts : TS_W'(exp_ts);
        consec4 = 1'b1;
        repeat (len) step();
        consec4 = 1'b0;
        if (store) sb.push_back({st, LEN_W'(exp_len)});
        if (pop_at_end) evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        repeat (gap - 1) step();
    endtask

    task automatic pop_n(input int n);
        evt_ready = 1'b1;
        repeat (n) step();
        evt_ready = 1'b0;
    endtask

    task automatic drain(input int exp_n);
        int n;
        n = 0;
        evt_ready = 1'b1;
        while (evt_valid && n < 16) begin
            step();
            n++;
        end
        evt_ready = 1'b0;
        check("drain_count", 32'(n), 32'(exp_n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #3;
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_ts", 32'(evt_ts), 0);
        check("rst_len", 32'(evt_len), 0);
        check("rst_count", 32'(evt_count), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_busy", 32'(busy), 0);
        #9 RST = 1'b1;
        step();

        // Single 6-cycle run from ts=10
        wait_ts(10);
        sb.push_back({4'd10, 4'd6});
        consec4 = 1'b1;
        step();
        check("run_busy", 32'(busy), 1);
        repeat (5) step();
        consec4 = 1'b0;
        step();
        check("single_valid", 32'(evt_valid), 1);
        check("single_count", 32'(evt_count), 1);
        check("single_busy", 32'(busy), 0);
        drain(1);

        // 1-cycle pulse is below MIN_LEN, 3-cycle run qualifies
        clr_pulse();
        check("clr_count", 32'(evt_count), 0);
        run(1, 2, 1'b0, -1, 0, 1'b0);
        run(3, 2, 1'b1, -1, 3, 1'b0);
        check("minlen_count", 32'(evt_count), 1);
        check("minlen_valid", 32'(evt_valid), 1);
        drain(1);

        // Overflow with consumer stalled
        clr_pulse();
        for (int i = 0; i < 4; i++) run(2, 2, 1'b1, -1, 2, 1'b0);
        check("fill_overflow", 32'(overflow), 0);
        check("fill_count", 32'(evt_count), 4);
        run(2, 2, 1'b0, -1, 2, 1'b0);
        check("ovf_overflow", 32'(overflow), 1);
        check("ovf_count", 32'(evt_count), 5);
        check("ovf_valid", 32'(evt_valid), 1);
        pop_n(2);
        check("ovf_valid_after_pops", 32'(evt_valid), 1);
        clr_pulse();
        sb.delete();
        check("clr_valid", 32'(evt_valid), 0);
        check("clr_overflow", 32'(overflow), 0);
        check("clr_count2", 32'(evt_count), 0);

        // Full FIFO with a pop on the edge the 5th run ends
        for (int i = 0; i < 4; i++) run(2, 2, 1'b1, -1, 2, 1'b0);
        run(3, 2, 1'b1, -1, 3, 1'b1);
        check("fullpop_overflow", 32'(overflow), 0);
        check("fullpop_count", 32'(evt_count), 5);
        check("fullpop_valid", 32'(evt_valid), 1);
        drain(4);

        // Length saturation and timestamp wrap
        clr_pulse();
        wait_ts(14);
        run(20, 1, 1'b1, 14, 15, 1'b0);
        run(2, 2, 1'b1, 3, 2, 1'b0);
        check("sat_count", 32'(evt_count), 2);
        drain(2);

        // Async reset during the third edge of a run
        consec4 = 1'b1;
        step();
        step();
        check("pre_rst_busy", 32'(busy), 1);
        #8 RST = 1'b0;
        #2 RST = 1'b1;
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_count", 32'(evt_count), 0);
        check("post_rst_valid", 32'(evt_valid), 0);
        step();
        check("restart_busy", 32'(busy), 1);
        step();
        step();
        sb.push_back({4'd0, 4'd3});
        consec4 = 1'b0;
        step();
        check("restart_count", 32'(evt_count), 1);
        drain(1);

        check("sb_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
